// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:4 demultiplexer and its round-robin pointer.
package demux_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_PARTIAL  = 2'd1,
    ST_COMPLETE = 2'd2
  } frame_state_t;

  function automatic logic [NCH-1:0] onehot4(input logic [SELW-1:0] sel);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_ptr.sv
// 2-bit wrap-around pointer with enable and synchronous clear.
module rr_ptr
  import demux_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [SELW-1:0] ptr
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = ptr_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/demux1x4_seq.sv
// Registered 1:4 demultiplexer with manual or round-robin channel select,
// per-channel fill flags and a one-cycle frame-complete pulse.
module demux1x4_seq
  import demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           valid,
  input  logic           auto,
  input  logic           s1,
  input  logic           s0,
  input  logic           clr,
  output logic [W-1:0]   o3,
  output logic [W-1:0]   o2,
  output logic [W-1:0]   o1,
  output logic [W-1:0]   o0,
  output logic [3:0]     filled,
  output logic           frame_done,
  output logic [1:0]     ptr
);

  logic [W-1:0]    ch_q [NCH];
  logic [W-1:0]    ch_d [NCH];
  logic [NCH-1:0]  filled_q;
  logic [NCH-1:0]  filled_d;
  logic            frame_done_q;
  logic            frame_done_d;
  frame_state_t    state_q;
  frame_state_t    state_d;

  logic [SELW-1:0] ptr_w;
  logic [SELW-1:0] tgt;
  logic [NCH-1:0]  fill_nxt;
  frame_state_t    frame_st;

  rr_ptr u_rr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (valid & auto),
    .clr (clr),
    .ptr (ptr_w)
  );

  assign tgt = auto ? ptr_w : {s1, s0};

  always_comb begin
    ch_d         = ch_q;
    filled_d     = filled_q;
    state_d      = state_q;
    frame_done_d = 1'b0;
    fill_nxt     = (state_q == ST_EMPTY) ? onehot4(tgt) : (filled_q | onehot4(tgt));
    frame_st     = state_q;

    if (clr) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_d[i] = '0;
      end
      filled_d = '0;
      state_d  = ST_EMPTY;
    end else if (valid) begin
      ch_d[tgt] = din;
      frame_st  = (&fill_nxt) ? ST_COMPLETE : ST_PARTIAL;
      // COMPLETE is never registered: it folds straight back to EMPTY.
      if (frame_st == ST_COMPLETE) begin
        filled_d     = '0;
        frame_done_d = 1'b1;
        state_d      = ST_EMPTY;
      end else begin
        filled_d = fill_nxt;
        state_d  = ST_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_q[i] <= '0;
      end
      filled_q     <= '0;
      frame_done_q <= 1'b0;
      state_q      <= ST_EMPTY;
    end else begin
      ch_q         <= ch_d;
      filled_q     <= filled_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
    end
  end

  assign o0         = ch_q[0];
  assign o1         = ch_q[1];
  assign o2         = ch_q[2];
  assign o3         = ch_q[3];
  assign filled     = filled_q;
  assign frame_done = frame_done_q;
  assign ptr        = ptr_w;

endmodule

// File: tb/tb_demux1x4_seq.sv
// Directed plus randomized bench for demux1x4_seq against a behavioural channel model.
module tb_demux1x4_seq;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         valid = 1'b0;
  logic         auto = 1'b0;
  logic         s1 = 1'b0;
  logic         s0 = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] o3, o2, o1, o0;
  logic [3:0]   filled;
  logic         frame_done;
  logic [1:0]   ptr;

  demux1x4_seq #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .valid      (valid),
    .auto       (auto),
    .s1         (s1),
    .s0         (s0),
    .clr        (clr),
    .o3         (o3),
    .o2         (o2),
    .o1         (o1),
    .o0         (o0),
    .filled     (filled),
    .frame_done (frame_done),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: channel contents, set of channels seen this frame, pointer, pulse.
  int m_o [4];
  bit m_seen [4];
  int m_ptr;
  int m_fd;
  int pulse_cnt;
  int last_pulse_cyc;
  int cyc_no;

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int m_filled();
    int f = 0;
    for (int i = 0; i < 4; i++) if (m_seen[i]) f += (1 << i);
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_o[i] = 0;
      m_seen[i] = 0;
    end
    m_ptr = 0;
    m_fd  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".o0"}, int'(o0), m_o[0]);
    chk({tag, ".o1"}, int'(o1), m_o[1]);
    chk({tag, ".o2"}, int'(o2), m_o[2]);
    chk({tag, ".o3"}, int'(o3), m_o[3]);
    chk({tag, ".filled"}, int'(filled), m_filled());
    chk({tag, ".frame_done"}, int'(frame_done), m_fd);
    chk({tag, ".ptr"}, int'(ptr), m_ptr);
  endtask

  // One clock: apply inputs away from the edge, advance the model, check after the edge.
  task automatic cyc(input string tag, input bit v, input bit a, input int sel,
                     input int d, input bit c);
    int t;
    int n;
    @(negedge clk);
    valid = v; auto = a; s1 = sel[1]; s0 = sel[0]; din = W'(d); clr = c;
    @(posedge clk);
    cyc_no++;
    if (c) begin
      m_reset();
    end else if (v) begin
      t = a ? m_ptr : (sel % 4);
      m_o[t] = d % (1 << W);
      m_seen[t] = 1;
      if (a) m_ptr = (m_ptr + 1) % 4;
      n = 0;
      for (int i = 0; i < 4; i++) n += m_seen[i];
      if (n == 4) begin
        for (int i = 0; i < 4; i++) m_seen[i] = 0;
        m_fd = 1;
      end else begin
        m_fd = 0;
      end
    end else begin
      m_fd = 0;
    end
    #1;
    if (frame_done === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc_no;
    end
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    m_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0; clr = 1'b0;
  endtask

  initial begin
    int first_pulse;
    m_reset();
    cyc_no = 0;
    pulse_cnt = 0;
    last_pulse_cyc = 0;

    #12 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame
    cyc("mf_w0", 1, 1, 0, 1, 0);
    cyc("mf_w1", 1, 1, 0, 1, 0);
    async_reset("midframe_rst");

    // Auto sequence 1,0,1,1
    cyc("auto0", 1, 1, 0, 1, 0);
    cyc("auto1", 1, 1, 0, 0, 0);
    cyc("auto2", 1, 1, 0, 1, 0);
    pulse_cnt = 0;
    cyc("auto3", 1, 1, 0, 1, 0);
    chk("auto_pulse_hi", int'(frame_done), 1);
    cyc("auto_idle", 0, 1, 0, 0, 0);
    chk("auto_pulse_once", pulse_cnt, 1);

    // Manual select 10
    cyc("clr_a", 0, 0, 0, 0, 1);
    cyc("man2", 1, 0, 2, 1, 0);
    chk("man2_filled", int'(filled), 4);

    // Duplicate write on ch3
    cyc("clr_b", 0, 0, 0, 0, 1);
    pulse_cnt = 0;
    cyc("dup3a", 1, 0, 3, 1, 0);
    cyc("dup3b", 1, 0, 3, 0, 0);
    cyc("dup0", 1, 0, 0, 1, 0);
    cyc("dup1", 1, 0, 1, 1, 0);
    chk("dup_nopulse", pulse_cnt, 0);
    cyc("dup2", 1, 0, 2, 1, 0);
    cyc("dup_idle", 0, 0, 0, 0, 0);
    chk("dup_onepulse", pulse_cnt, 1);

    // clr wins over valid with filled=0111
    cyc("pre0", 1, 0, 0, 1, 0);
    cyc("pre1", 1, 0, 1, 1, 0);
    cyc("pre2a", 1, 1, 0, 1, 0);
    cyc("pre2b", 1, 0, 2, 1, 0);
    chk("pre_filled", int'(filled), 7);
    cyc("clr_valid", 1, 1, 3, 1, 1);

    // Eight auto strobes across two frames
    pulse_cnt = 0;
    first_pulse = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc("wrap", 1, 1, 0, int'($urandom_range(0, 1)), 0);
      if (k == 4) begin
        chk("wrap_ptr4", int'(ptr), 0);
        first_pulse = last_pulse_cyc;
      end
    end
    chk("wrap_ptr8", int'(ptr), 0);
    chk("wrap_pulses", pulse_cnt, 2);
    chk("wrap_spacing", last_pulse_cyc - first_pulse, 4);

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      cyc("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux1x4_seq.md
# demux1x4_seq

Registered 1-to-4 demultiplexer: the distributing counterpart of the team's 4:1 mux. A strobed input word is routed into one of four held output channels. The channel is chosen either by the external select pins `s1`/`s0` or by an internal round-robin pointer. Per-channel fill flags and a frame-complete pulse let downstream logic (display/visitor-count registers) know when all four channels have been refreshed.

## Interface
- `W`, default 1: data width of `din` and each output channel.

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `din`  in  W  data to route
- `valid`  in  1  write strobe; `din` is captured on any rising edge where high
- `auto`  in  1  1: internal pointer selects channel; 0: `{s1,s0}` selects
- `s1`, `s0`  in  1 each  manual select, MSB/LSB; ignored when `auto`=1
- `clr`  in  1  synchronous clear of channels, flags and pointer
- `o3`, `o2`, `o1`, `o0`  out  W each  held channel registers
- `filled`  out  4  bit n set once channel n has been written in the current frame
- `frame_done`  out  1  one-cycle pulse when the fourth distinct channel of a frame is written
- `ptr`  out  2  current round-robin pointer value

## Operation
- Target channel: `tgt = auto ? ptr : {s1,s0}`.
- Edge with `clr`=1: `o0..o3`, `filled` and `ptr` go to 0, and `frame_done` goes to 0. `clr` has priority over `valid`.
- Edge with `valid`=1 and `clr`=0:
  - `o[tgt]` gets `din`; all other channels hold.
  - `filled[tgt]` gets 1.
  - If `auto`=1, `ptr` gets `ptr+1` modulo 4, so 3 wraps to 0.
- Manual writes (`auto`=0) never move `ptr`. Toggling `auto` does not reset `ptr`.
- Rewriting an already-filled channel in the same frame overwrites its data. `filled` is unchanged and no pulse is generated.
- Frame FSM:
  - States: EMPTY (`filled`=0000), PARTIAL (some bits set), COMPLETE.
  - COMPLETE is transient. On the write edge where `filled | onehot(tgt)` equals 1111: `filled` gets 0000, `frame_done` gets 1, and the state returns to EMPTY.
  - `frame_done` deasserts on the next edge, unless that edge itself completes a frame. That cannot happen at W≥1 with four channels, so the pulse is always exactly one cycle.
- Edges with `valid`=0 and `clr`=0: all state holds and `frame_done` gets 0.
- Reset (any time, including mid-frame): `o0..o3` = 0, `filled` = 0000, `frame_done` = 0, `ptr` = 00, state EMPTY. Outputs hold reset values until the first edge after `rst` falls.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Write latency is 1 cycle: data presented with `valid` on edge k is visible on `o[tgt]` after edge k.
- `frame_done` is high for the single cycle following the completing write edge. `filled` reads 0000 in that same cycle.
- `ptr` updates on the same edge as the write it served. Back-to-back `valid` in auto mode therefore writes channels 0,1,2,3,0,… on consecutive edges.
- Select and `auto` are sampled on the write edge only. They may change freely between strobes.

## Structure
- Shared package `demux_pkg`:
  - `NCH=4`
  - `SELW=2`
  - frame-state encoding (EMPTY, PARTIAL, COMPLETE)
  - function `onehot4(sel)`
- One natural sub-module: `rr_ptr`, a 2-bit wrap-around counter with enable (`valid & auto`) and synchronous clear. It also serves the display scanner.
- Top level contains the target mux, the four channel registers, the fill-flag register and the pulse flop.

## Test plan
- Reset mid-frame: write ch0=1, ch1=1 in auto mode, assert `rst` asynchronously between edges.
  - Expected: all `o*`=0, `filled`=0000 and `ptr`=00 immediately, without waiting for an edge.
- Auto sequence, W=1: with `valid` held high, drive `din`=1,0,1,1 on four consecutive edges.
  - Expected: `o0`=1, `o1`=0, `o2`=1, `o3`=1.
  - `ptr` steps 1,2,3,0.
  - `frame_done` is high for exactly the cycle after the 4th edge, with `filled`=0000 in that cycle.
- Manual select: `auto`=0, `{s1,s0}`=10, `din`=1, one strobe.
  - Expected: only `o2`=1, `filled`=0100, `ptr` unchanged at 00.
- Duplicate write: manually write ch3 twice (`din`=1 then 0), then ch0, ch1, ch2.
  - Expected: `o3`=0 and no pulse after the second write.
  - Exactly one `frame_done` after the ch2 write.
- `clr` vs `valid`: `clr`=1 and `valid`=1 on the same edge while `filled`=0111.
  - Expected: all channels 0, `filled`=0000, `ptr`=00, no `frame_done`.
- Wrap-around across frames: 8 auto strobes.
  - Expected: two `frame_done` pulses, 4 cycles apart.
  - `ptr` returns to 00 after strobes 4 and 8.
